iic_arbiter: RTL and testbench
==============================

Name: iic_arbiter

Overview:
Shares one iic_dri instance (2-byte address, 1 data byte) between two register-sequencing clients, e.g. the receive-side and transmit-side chip init controllers. Each client keeps its native pulse/busy/byte_over handshake and sees a private driver. The arbiter captures each client's request, serves requests round-robin, and routes results back only to the granted client. Per-transaction timeouts prevent a hung bus from blocking both clients.

Parameters:
ADDR_W, 16, register address width.
RISE_TO, 16, max cycles from drv_pluse to drv_busy rising before abort.
XFER_TO, 50000, max cycles with drv_busy high before abort (covers T_WR at 10 MHz).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
c0_trig / c1_trig  input  1  one-cycle request pulse from client 0 / 1.
c0_w_r / c1_w_r  input  1  direction: 1 = write, 0 = read.
c0_device_id / c1_device_id  input  8  I2C device address.
c0_addr / c1_addr  input  ADDR_W  register address.
c0_data_in / c1_data_in  input  8  write data.
c0_busy / c1_busy  output  1  request pending or in service.
c0_byte_over / c1_byte_over  output  1  driver byte_over, routed to granted client only.
c0_data_out / c1_data_out  output  8  read data, held until the next byte_over for that client.
c0_err / c1_err  output  1  one-cycle pulse when that client's transaction times out.
drv_pluse  output  1  trigger to iic_dri.
drv_w_r  output  1  to iic_dri.
drv_device_id  output  8  to iic_dri.
drv_addr  output  ADDR_W  to iic_dri.
drv_data_in  output  8  to iic_dri.
drv_busy  input  1  from iic_dri.
drv_byte_over  input  1  from iic_dri.
drv_data_out  input  8  from iic_dri.
grant  output  2  one-hot owner of the driver; 00 when idle.

Behaviour:
- Reset: all outputs 0; pending flags 0; state IDLE; round-robin pointer selects client 0 first. Reset mid-transfer drops all pending and in-flight requests without error pulses.
- Capture: cN_trig while cN_busy=0 latches w_r, device_id, addr, data_in into hold register N and sets pending N; cN_busy goes high the next cycle. cN_trig while cN_busy=1 is ignored, with no effect on state.
- cN_busy = pending N OR (grant[N] AND state != IDLE). It stays high until the cycle after completion.
- IDLE: if any request is pending, select by round-robin: the client not served last wins a tie; a single pending request wins outright. Load drv_* from the hold register, set grant, then go to ISSUE. Hold registers drive drv_* continuously while granted.
- ISSUE: drv_pluse=1 for exactly one cycle; clear the rise counter; go to WAIT_RISE.
- WAIT_RISE: if drv_busy=1, go to WAIT_DONE and clear the transfer counter. Otherwise increment the counter; at RISE_TO, abort.
- WAIT_DONE: if drv_busy=0, complete. Otherwise increment the counter; at XFER_TO, abort.
- Complete: clear pending of the granted client; update the pointer to the granted client; grant=00; return to IDLE. At least one idle cycle separates consecutive drv_pluse pulses.
- Abort: same as complete, plus a one-cycle cN_err pulse for the granted client.
- Routing: cN_byte_over = drv_byte_over AND grant[N], combinational. On drv_byte_over with grant[N], register drv_data_out into cN_data_out; it is valid from the next cycle. The non-granted client's byte_over stays 0 and its data_out is unchanged.
- drv_byte_over outside WAIT_DONE is ignored.
- Simultaneous trig from both clients in the same cycle: both are latched. The pointer decides order; the second client is served after the first completes.
- Counters saturate at their limit; width is ceil(log2(XFER_TO+1)).

Test Plan:
- Single write: c0_trig, addr 0x1003, data 0x5A; driver model raises busy after 3 cycles and holds it 40 cycles -> drv_pluse once with drv_addr=0x1003 and drv_data_in=0x5A; c0_busy high throughout; c1 outputs stay 0; grant=01 then 00.
- Read routing: c1 reads with the model returning 0xC4 on byte_over -> c1_byte_over pulses, c1_data_out=0xC4, c0_data_out unchanged, c0_byte_over=0.
- Simultaneous trig after reset -> c0 served first, then c1. Repeat with both pending -> c1 served first (alternation). Exactly 2 drv_pluse pulses per pair, separated by at least one idle cycle.
- Retrigger while busy: c0_trig again during WAIT_DONE with addr 0xFFFF -> ignored; exactly one drv_pluse total; drv_addr never 0xFFFF.
- Timeout: model never raises busy -> abort after RISE_TO=16 cycles, c0_err one-cycle pulse, c0_busy falls, a pending c1 request is then issued normally. Model holds busy beyond XFER_TO -> c0_err pulse.
- Reset mid-transfer in WAIT_DONE -> all outputs 0 asynchronously; no err pulse; a new c0_trig after release is served normally.

Source files
------------

// File: rtl/iic_arbiter.sv
// Round-robin arbiter that lets two register-sequencing clients share one iic_dri.
// Each client keeps a private pulse/busy/byte_over view; hung transfers are aborted by timeouts.
module iic_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RISE_TO = 16,
  parameter int unsigned XFER_TO = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_trig,
  input  logic              c0_w_r,
  input  logic [7:0]        c0_device_id,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [7:0]        c0_data_in,
  output logic              c0_busy,
  output logic              c0_byte_over,
  output logic [7:0]        c0_data_out,
  output logic              c0_err,
  input  logic              c1_trig,
  input  logic              c1_w_r,
  input  logic [7:0]        c1_device_id,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [7:0]        c1_data_in,
  output logic              c1_busy,
  output logic              c1_byte_over,
  output logic [7:0]        c1_data_out,
  output logic              c1_err,
  output logic              drv_pluse,
  output logic              drv_w_r,
  output logic [7:0]        drv_device_id,
  output logic [ADDR_W-1:0] drv_addr,
  output logic [7:0]        drv_data_in,
  input  logic              drv_busy,
  input  logic              drv_byte_over,
  input  logic [7:0]        drv_data_out,
  output logic [1:0]        grant
);

  localparam int unsigned CNT_W = $clog2(XFER_TO + 1);

  typedef struct packed {
    logic              w_r;
    logic [7:0]        device_id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RISE, WAIT_DONE} state_t;

  state_t            state_q;
  req_t              c_req      [2];
  req_t              hold_q     [2];
  logic [7:0]        data_out_q [2];
  req_t              drv_q;
  logic [1:0]        trig;
  logic [1:0]        pending_q;
  logic [1:0]        grant_q;
  logic [1:0]        err_q;
  logic              pluse_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        busy_c;
  logic [1:0]        bo_c;
  logic              sel_c;
  logic              gsel_c;
  logic              xfer_end_c;
  logic              xfer_abort_c;

  assign trig     = {c1_trig, c0_trig};
  assign c_req[0] = {c0_w_r, c0_device_id, c0_addr, c0_data_in};
  assign c_req[1] = {c1_w_r, c1_device_id, c1_addr, c1_data_in};

  assign busy_c = pending_q | (grant_q & {2{state_q != IDLE}});
  // byte_over only counts while a granted transfer is actually in flight
  assign bo_c   = grant_q & {2{drv_byte_over && (state_q == WAIT_DONE)}};
  assign gsel_c = grant_q[1];

  // Tie goes to the client not served last; a lone request wins outright.
  always_comb begin
    sel_c        = pending_q[1];
    xfer_end_c   = 1'b0;
    xfer_abort_c = 1'b0;
    if (pending_q == 2'b11) sel_c = ~last_q;
    case (state_q)
      WAIT_RISE: xfer_abort_c = !drv_busy && (cnt_q >= CNT_W'(RISE_TO - 1));
      WAIT_DONE: begin
        xfer_end_c   = !drv_busy;
        xfer_abort_c = drv_busy && (cnt_q >= CNT_W'(XFER_TO - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      err_q     <= '0;
      pluse_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      drv_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        hold_q[i]     <= '0;
        data_out_q[i] <= '0;
      end
    end else begin
      pluse_q <= 1'b0;
      err_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        if (trig[i] && !busy_c[i]) begin
          hold_q[i]    <= c_req[i];
          pending_q[i] <= 1'b1;
        end
        if (bo_c[i]) data_out_q[i] <= drv_data_out;
      end
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            drv_q   <= hold_q[sel_c];
            grant_q <= sel_c ? 2'b10 : 2'b01;
            pluse_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (drv_busy) begin
            cnt_q   <= '0;
            state_q <= WAIT_DONE;
          end else if (!xfer_abort_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (drv_busy && !xfer_abort_c) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
      // Completion and abort both release the driver; abort also flags the owner.
      if (xfer_end_c || xfer_abort_c) begin
        pending_q[gsel_c] <= 1'b0;
        last_q            <= gsel_c;
        grant_q           <= '0;
        state_q           <= IDLE;
        if (xfer_abort_c) err_q[gsel_c] <= 1'b1;
      end
    end
  end

  assign c0_busy       = busy_c[0];
  assign c1_busy       = busy_c[1];
  assign c0_byte_over  = bo_c[0];
  assign c1_byte_over  = bo_c[1];
  assign c0_data_out   = data_out_q[0];
  assign c1_data_out   = data_out_q[1];
  assign c0_err        = err_q[0];
  assign c1_err        = err_q[1];
  assign drv_pluse     = pluse_q;
  assign drv_w_r       = drv_q.w_r;
  assign drv_device_id = drv_q.device_id;
  assign drv_addr      = drv_q.addr;
  assign drv_data_in   = drv_q.data;
  assign grant         = grant_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter with a cycle-based iic_dri model.
// XFER_TO is shortened so the transfer-timeout scenario stays brief.
module tb_iic_arbiter;

  localparam int unsigned XFER_TO_TB = 500;

  logic        clk;
  logic        rst_n;
  logic        c0_trig, c0_w_r, c1_trig, c1_w_r;
  logic [7:0]  c0_device_id, c0_data_in, c1_device_id, c1_data_in;
  logic [15:0] c0_addr, c1_addr;
  logic        c0_busy, c0_byte_over, c0_err, c1_busy, c1_byte_over, c1_err;
  logic [7:0]  c0_data_out, c1_data_out;
  logic        drv_pluse, drv_w_r;
  logic [7:0]  drv_device_id, drv_data_in, drv_data_out;
  logic [15:0] drv_addr;
  logic        drv_busy, drv_byte_over;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_err = 0;

  iic_arbiter #(.ADDR_W(16), .RISE_TO(16), .XFER_TO(XFER_TO_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_trig(c0_trig), .c0_w_r(c0_w_r), .c0_device_id(c0_device_id), .c0_addr(c0_addr),
    .c0_data_in(c0_data_in), .c0_busy(c0_busy), .c0_byte_over(c0_byte_over),
    .c0_data_out(c0_data_out), .c0_err(c0_err),
    .c1_trig(c1_trig), .c1_w_r(c1_w_r), .c1_device_id(c1_device_id), .c1_addr(c1_addr),
    .c1_data_in(c1_data_in), .c1_busy(c1_busy), .c1_byte_over(c1_byte_over),
    .c1_data_out(c1_data_out), .c1_err(c1_err),
    .drv_pluse(drv_pluse), .drv_w_r(drv_w_r), .drv_device_id(drv_device_id),
    .drv_addr(drv_addr), .drv_data_in(drv_data_in), .drv_busy(drv_busy),
    .drv_byte_over(drv_byte_over), .drv_data_out(drv_data_out), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // iic_dri model: rise delay (-1 = never), busy hold time, optional read byte.
  int         model_rise  = 3;
  int         model_hold  = 40;
  bit         model_read  = 1'b0;
  logic [7:0] model_rdata = 8'h00;
  int         m_phase     = 0;
  int         m_cnt       = 0;
  int         pulses      = 0;
  int         adj_pulses  = 0;
  int         bad_addr    = 0;
  logic       prev_pluse  = 1'b0;
  logic [1:0]  pulse_grant [$];
  logic [15:0] pulse_addr  [$];
  logic [7:0]  pulse_data  [$];
  logic        pulse_wr    [$];

  initial begin
    drv_busy      = 1'b0;
    drv_byte_over = 1'b0;
    drv_data_out  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        m_phase       = 0;
        drv_busy      = 1'b0;
        drv_byte_over = 1'b0;
        prev_pluse    = 1'b0;
      end else begin
        if (drv_pluse) begin
          pulses++;
          if (prev_pluse) adj_pulses++;
          pulse_grant.push_back(grant);
          pulse_addr.push_back(drv_addr);
          pulse_data.push_back(drv_data_in);
          pulse_wr.push_back(drv_w_r);
        end
        if (grant != 2'b00 && drv_addr == 16'hFFFF) bad_addr++;
        prev_pluse = drv_pluse;
        case (m_phase)
          0: if (drv_pluse && model_rise >= 0) begin m_cnt = model_rise; m_phase = 1; end
          1: begin
            m_cnt--;
            if (m_cnt <= 0) begin drv_busy = 1'b1; m_cnt = model_hold; m_phase = 2; end
          end
          2: begin
            m_cnt--;
            if (m_cnt <= 0) begin
              if (model_read) begin
                drv_data_out  = model_rdata;
                drv_byte_over = 1'b1;
                m_phase       = 3;
              end else begin
                drv_busy = 1'b0;
                m_phase  = 0;
              end
            end
          end
          default: begin drv_byte_over = 1'b0; drv_busy = 1'b0; m_phase = 0; end
        endcase
      end
    end
  end

  task automatic set_req(input int who, input logic wr, input logic [7:0] id,
                         input logic [15:0] addr, input logic [7:0] d);
    if (who == 0) begin
      c0_trig = 1'b1; c0_w_r = wr; c0_device_id = id; c0_addr = addr; c0_data_in = d;
    end else begin
      c1_trig = 1'b1; c1_w_r = wr; c1_device_id = id; c1_addr = addr; c1_data_in = d;
    end
  endtask

  task automatic clear_trig();
    c0_trig = 1'b0;
    c1_trig = 1'b0;
  endtask

  // Bounded wait for both clients and the driver model to go quiet.
  task automatic wait_done(input int max, output bit ok, output int errs);
    ok = 1'b0;
    errs = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (c0_err || c1_err) errs++;
      if (!c0_busy && !c1_busy && m_phase == 0 && !drv_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({c0_busy, c1_busy, c0_err, c1_err, c0_byte_over, c1_byte_over, c0_data_out, c1_data_out,
         drv_pluse, drv_w_r, drv_device_id, drv_addr, drv_data_in, grant} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b%b grant=%b drv_addr=%h expected all zero",
               c1_busy, c0_busy, grant, drv_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({c0_busy, c1_busy, grant, drv_pluse} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy=%b%b grant=%b pluse=%b expected 0",
               c1_busy, c0_busy, grant, drv_pluse);
    end
  endtask

  task automatic test_single_write();
    int base = pulses;
    int c1_bad = 0;
    int bad_grant = 0;
    bit saw_g = 1'b0;
    bit ok = 1'b0;
    int errs;
    model_rise = 3; model_hold = 40; model_read = 1'b0;
    @(negedge clk); set_req(0, 1'b1, 8'hA0, 16'h1003, 8'h5A);
    @(negedge clk); clear_trig();
    n_cmp++;
    if (c0_busy !== 1'b1) begin
      n_err++; $display("FAIL write_busy_rise: got %b expected 1", c0_busy);
    end
    for (int i = 0; i < 200; i++) begin
      if (!c0_busy) begin ok = 1'b1; break; end
      if ({c1_busy, c1_err, c1_byte_over, c1_data_out} !== '0) c1_bad++;
      if (grant == 2'b01) saw_g = 1'b1;
      if (grant != 2'b01 && grant != 2'b00) bad_grant++;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL write_complete: got busy stuck expected release"); end
    n_cmp++;
    if (drv_busy !== 1'b0 || m_phase != 0) begin
      n_err++; $display("FAIL write_busy_until_done: got drv_busy=%b expected 0 at c0_busy fall", drv_busy);
    end
    n_cmp++;
    if (pulses - base != 1) begin
      n_err++; $display("FAIL write_pulses: got %0d expected 1", pulses - base);
    end else begin
      n_cmp++;
      if ({pulse_wr[base], pulse_addr[base], pulse_data[base]} !== {1'b1, 16'h1003, 8'h5A}) begin
        n_err++;
        $display("FAIL write_payload: got wr=%b addr=%h data=%h expected 1/1003/5a",
                 pulse_wr[base], pulse_addr[base], pulse_data[base]);
      end
    end
    n_cmp++;
    if (c1_bad != 0 || bad_grant != 0 || !saw_g || grant !== 2'b00) begin
      n_err++;
      $display("FAIL write_isolation: got c1_bad=%0d bad_grant=%0d saw01=%b grant=%b expected 0/0/1/00",
               c1_bad, bad_grant, saw_g, grant);
    end
    wait_done(20, ok, errs);
  endtask

  task automatic test_simultaneous(input logic [1:0] first);
    int base = pulses;
    bit ok;
    int errs;
    logic [1:0]  second = ~first;
    logic [15:0] first_addr = (first == 2'b01) ? 16'h2000 : 16'h3000;
    model_rise = 2; model_hold = 10; model_read = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 8'hA0, 16'h2000, 8'h11);
    set_req(1, 1'b1, 8'hA2, 16'h3000, 8'h22);
    @(negedge clk); clear_trig();
    n_cmp++;
    if ({c1_busy, c0_busy} !== 2'b11) begin
      n_err++; $display("FAIL simul_both_busy: got %b%b expected 11", c1_busy, c0_busy);
    end
    wait_done(300, ok, errs);
    n_cmp++;
    if (!ok || pulses - base != 2) begin
      n_err++; $display("FAIL simul_pulses: got %0d (done=%b) expected 2", pulses - base, ok);
    end else begin
      n_cmp++;
      if ({pulse_grant[base], pulse_grant[base+1], pulse_addr[base]} !== {first, second, first_addr}) begin
        n_err++;
        $display("FAIL simul_order: got %b,%b addr %h expected %b,%b addr %h",
                 pulse_grant[base], pulse_grant[base+1], pulse_addr[base], first, second, first_addr);
      end
    end
    n_cmp++;
    if (adj_pulses != 0 || errs != 0) begin
      n_err++; $display("FAIL simul_gap: got adjacent=%0d errs=%0d expected 0/0", adj_pulses, errs);
    end
  endtask

  task automatic test_read_routing();
    int base = pulses;
    int c0_bo = 0;
    int c1_bo = 0;
    bit ok;
    int errs;
    model_rise = 3; model_hold = 10; model_read = 1'b1; model_rdata = 8'hC4;
    @(negedge clk); set_req(1, 1'b0, 8'hA1, 16'h0042, 8'h00);
    @(negedge clk); clear_trig();
    for (int i = 0; i < 100 && c1_busy; i++) begin
      if (c1_byte_over) c1_bo++;
      if (c0_byte_over) c0_bo++;
      @(negedge clk);
    end
    wait_done(20, ok, errs);
    model_read = 1'b0;
    n_cmp++;
    if (c1_bo != 1 || c0_bo != 0) begin
      n_err++; $display("FAIL read_byte_over: got c1=%0d c0=%0d expected 1/0", c1_bo, c0_bo);
    end
    n_cmp++;
    if (c1_data_out !== 8'hC4) begin
      n_err++; $display("FAIL read_c1_data: got %h expected c4", c1_data_out);
    end
    n_cmp++;
    if (c0_data_out !== 8'h00) begin
      n_err++; $display("FAIL read_c0_data: got %h expected 00", c0_data_out);
    end
    n_cmp++;
    if (pulses - base != 1 || pulse_grant[base] !== 2'b10 || pulse_wr[base] !== 1'b0) begin
      n_err++; $display("FAIL read_issue: got pulses=%0d expected 1 read from c1", pulses - base);
    end
  endtask

  task automatic test_retrigger();
    int base = pulses;
    bit ok;
    int errs;
    model_rise = 3; model_hold = 30; model_read = 1'b0;
    @(negedge clk); set_req(0, 1'b1, 8'hA0, 16'h1111, 8'h33);
    @(negedge clk); clear_trig();
    for (int i = 0; i < 50 && !drv_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 8'hA0, 16'hFFFF, 8'h44);
    @(negedge clk); clear_trig();
    wait_done(200, ok, errs);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!ok || pulses - base != 1 || bad_addr != 0) begin
      n_err++;
      $display("FAIL retrig_ignored: got pulses=%0d bad_addr=%0d expected 1/0", pulses - base, bad_addr);
    end else begin
      n_cmp++;
      if (pulse_addr[base] !== 16'h1111) begin
        n_err++; $display("FAIL retrig_addr: got %h expected 1111", pulse_addr[base]);
      end
    end
  endtask

  task automatic test_rise_timeout();
    int base = pulses;
    int err_at = -1;
    bit ok;
    int errs;
    model_rise = -1; model_hold = 5; model_read = 1'b0;
    @(negedge clk); set_req(0, 1'b1, 8'hA0, 16'h4000, 8'h01);
    @(negedge clk); clear_trig(); set_req(1, 1'b1, 8'hA2, 16'h4001, 8'h02);
    for (int i = 1; i <= 100; i++) begin
      if (i == 2) clear_trig();
      if (c0_err) begin err_at = i; break; end
      @(negedge clk);
    end
    model_rise = 3;
    n_cmp++;
    if (err_at < 17 || err_at > 21) begin
      n_err++; $display("FAIL rise_timeout_time: got %0d expected 17..21 cycles", err_at);
    end
    n_cmp++;
    if ({c0_busy, c1_busy} !== 2'b01) begin
      n_err++; $display("FAIL rise_timeout_busy: got c0=%b c1=%b expected 0/1", c0_busy, c1_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (c0_err !== 1'b0) begin
      n_err++; $display("FAIL rise_err_width: got %b expected 0", c0_err);
    end
    wait_done(200, ok, errs);
    n_cmp++;
    if (!ok || errs != 0 || pulses - base != 2) begin
      n_err++; $display("FAIL rise_next_served: got pulses=%0d errs=%0d expected 2/0", pulses - base, errs);
    end else begin
      n_cmp++;
      if ({pulse_grant[base+1], pulse_addr[base+1]} !== {2'b10, 16'h4001}) begin
        n_err++; $display("FAIL rise_next_grant: got %b %h expected 10 4001",
                          pulse_grant[base+1], pulse_addr[base+1]);
      end
    end
  endtask

  task automatic test_xfer_timeout();
    int err_at = -1;
    bit ok;
    int errs;
    model_rise = 3; model_hold = 700; model_read = 1'b0;
    @(negedge clk); set_req(0, 1'b1, 8'hA0, 16'h4444, 8'h05);
    @(negedge clk); clear_trig();
    for (int i = 1; i <= 1000; i++) begin
      if (c0_err) begin err_at = i; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (err_at < 500 || err_at > 512) begin
      n_err++; $display("FAIL xfer_timeout_time: got %0d expected 500..512 cycles", err_at);
    end
    n_cmp++;
    if ({c0_busy, drv_busy, grant} !== 4'b0100) begin
      n_err++; $display("FAIL xfer_timeout_state: got busy=%b drv_busy=%b grant=%b expected 0/1/00",
                        c0_busy, drv_busy, grant);
    end
    wait_done(1000, ok, errs);
    n_cmp++;
    if (!ok || errs != 0) begin
      n_err++; $display("FAIL xfer_timeout_settle: got done=%b errs=%0d expected 1/0", ok, errs);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    int errs;
    model_rise = 3; model_hold = 40; model_read = 1'b0;
    @(negedge clk); set_req(0, 1'b1, 8'hA0, 16'h6666, 8'h07);
    @(negedge clk); clear_trig();
    for (int i = 0; i < 50 && !drv_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({c0_busy, c1_busy, c0_err, c1_err, c0_byte_over, c1_byte_over, c0_data_out, c1_data_out,
         drv_pluse, drv_w_r, drv_device_id, drv_addr, drv_data_in, grant} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: got busy=%b%b grant=%b drv_addr=%h c1_data=%h expected all zero",
               c1_busy, c0_busy, grant, drv_addr, c1_data_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = pulses;
    @(negedge clk); set_req(0, 1'b1, 8'hA0, 16'h5555, 8'h08);
    @(negedge clk); clear_trig();
    wait_done(200, ok, errs);
    n_cmp++;
    if (!ok || errs != 0 || pulses - base != 1) begin
      n_err++; $display("FAIL reset_mid_recover: got pulses=%0d errs=%0d expected 1/0", pulses - base, errs);
    end else begin
      n_cmp++;
      if (pulse_addr[base] !== 16'h5555) begin
        n_err++; $display("FAIL reset_mid_addr: got %h expected 5555", pulse_addr[base]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    c0_trig = 1'b0; c0_w_r = 1'b0; c0_device_id = '0; c0_addr = '0; c0_data_in = '0;
    c1_trig = 1'b0; c1_w_r = 1'b0; c1_device_id = '0; c1_addr = '0; c1_data_in = '0;
    test_reset();
    test_simultaneous(2'b01);
    test_single_write();
    test_simultaneous(2'b10);
    test_read_routing();
    test_retrigger();
    test_rise_timeout();
    test_xfer_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
